// File: rtl/dw_split_seq_pkg.sv
// Shared types and width helpers for the wide-to-narrow split sequencer.
package dw_split_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Number of narrow windows inside one wide word.
  function automatic int unsigned dw_n(input int unsigned in_lg, input int unsigned out_lg);
    return 32'd1 << (in_lg - out_lg);
  endfunction

  function automatic int unsigned dw_ib(input int unsigned in_lg);
    return 32'd1 << in_lg;
  endfunction

  function automatic int unsigned dw_ob(input int unsigned out_lg);
    return 32'd1 << out_lg;
  endfunction

endpackage

// File: rtl/dw_split_seq_nz_win_pick.sv
// Finds the lowest narrow window whose byte-enable slice is nonzero.
module nz_win_pick
  import dw_split_seq_pkg::*;
#(
  parameter  int unsigned IN_P_DW_BYTES  = 3,
  parameter  int unsigned OUT_P_DW_BYTES = 2,
  localparam int unsigned IB = dw_ib(IN_P_DW_BYTES),
  localparam int unsigned OB = dw_ob(OUT_P_DW_BYTES),
  localparam int unsigned N  = dw_n(IN_P_DW_BYTES, OUT_P_DW_BYTES),
  localparam int unsigned WW = IN_P_DW_BYTES - OUT_P_DW_BYTES
) (
  input  logic [IB-1:0] be_i,
  output logic          any_o,
  output logic [WW-1:0] idx_o
);

  // Scan high to low so the last hit is the lowest window.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (be_i[(N-1-k)*OB +: OB] != '0) begin
        any_o = 1'b1;
        idx_o = WW'(N-1-k);
      end
    end
  end

endmodule

// File: rtl/dw_split_seq.sv
// Splits one wide read/write into ascending narrow beats, one outstanding at a time.
module dw_split_seq
  import dw_split_seq_pkg::*;
#(
  parameter  int unsigned IN_P_DW_BYTES  = 3,
  parameter  int unsigned OUT_P_DW_BYTES = 2,
  parameter  int unsigned AW             = 32,
  localparam int unsigned IB  = dw_ib(IN_P_DW_BYTES),
  localparam int unsigned OB  = dw_ob(OUT_P_DW_BYTES),
  localparam int unsigned WW  = IN_P_DW_BYTES - OUT_P_DW_BYTES,
  localparam int unsigned OBW = OB * 8,
  localparam int unsigned HW  = AW - IN_P_DW_BYTES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [AW-1:0]   i_req_addr,
  input  logic [IB*8-1:0] i_req_wdat,
  input  logic [IB-1:0]   i_req_be,
  output logic            o_resp_valid,
  input  logic            i_resp_ready,
  output logic [IB*8-1:0] o_resp_rdat,
  output logic            o_dn_valid,
  input  logic            i_dn_ready,
  output logic            o_dn_we,
  output logic [AW-1:0]   o_dn_addr,
  output logic [OBW-1:0]  o_dn_wdat,
  output logic [OB-1:0]   o_dn_be,
  input  logic            i_dn_rvalid,
  input  logic [OBW-1:0]  i_dn_rdat
);

  state_e            state_q;
  logic              rdy_q, dn_valid_q, resp_valid_q, we_q, dn_we_q;
  logic [HW-1:0]     addr_q;
  logic [IB*8-1:0]   wdat_q, rdat_q;
  logic [IB-1:0]     be_q;
  logic [WW-1:0]     win_q;
  logic [AW-1:0]     dn_addr_q;
  logic [OBW-1:0]    dn_wdat_q;
  logic [OB-1:0]     dn_be_q;

  logic [IB-1:0]     be_clr, pick_be;
  logic              src_we;
  logic [HW-1:0]     src_hi;
  logic [IB*8-1:0]   src_wdat;
  logic              pick_any;
  logic [WW-1:0]     pick_idx;
  logic [AW-1:0]     dn_addr_d;
  logic [OBW-1:0]    dn_wdat_d;
  logic [OB-1:0]     dn_be_d;
  logic              unused_addr_lo;

  assign unused_addr_lo = ^i_req_addr[IN_P_DW_BYTES-1:0];

  // One picker serves both accept (fresh request) and beat completion (pending minus current).
  always_comb begin
    be_clr = be_q;
    be_clr[win_q*OB +: OB] = '0;
    if (state_q == IDLE) begin
      pick_be  = i_req_be;
      src_we   = i_req_we;
      src_hi   = i_req_addr[AW-1:IN_P_DW_BYTES];
      src_wdat = i_req_wdat;
    end else begin
      pick_be  = be_clr;
      src_we   = we_q;
      src_hi   = addr_q;
      src_wdat = wdat_q;
    end
  end

  nz_win_pick #(
    .IN_P_DW_BYTES (IN_P_DW_BYTES),
    .OUT_P_DW_BYTES(OUT_P_DW_BYTES)
  ) u_pick (
    .be_i (pick_be),
    .any_o(pick_any),
    .idx_o(pick_idx)
  );

  assign dn_addr_d = {src_hi, pick_idx, {OUT_P_DW_BYTES{1'b0}}};
  assign dn_wdat_d = src_wdat[pick_idx*OBW +: OBW];
  assign dn_be_d   = pick_be[pick_idx*OB +: OB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rdy_q        <= 1'b0;
      dn_valid_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      we_q         <= 1'b0;
      dn_we_q      <= 1'b0;
      addr_q       <= '0;
      wdat_q       <= '0;
      rdat_q       <= '0;
      be_q         <= '0;
      win_q        <= '0;
      dn_addr_q    <= '0;
      dn_wdat_q    <= '0;
      dn_be_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (rdy_q && i_req_valid) begin
            rdy_q  <= 1'b0;
            we_q   <= i_req_we;
            addr_q <= i_req_addr[AW-1:IN_P_DW_BYTES];
            wdat_q <= i_req_wdat;
            be_q   <= i_req_be;
            rdat_q <= '0;
            if (pick_any) begin
              win_q      <= pick_idx;
              dn_we_q    <= src_we;
              dn_addr_q  <= dn_addr_d;
              dn_wdat_q  <= dn_wdat_d;
              dn_be_q    <= dn_be_d;
              dn_valid_q <= 1'b1;
              state_q    <= CMD;
            end else begin
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end
          end
        end
        CMD: begin
          if (i_dn_ready) begin
            dn_valid_q <= 1'b0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (i_dn_rvalid) begin
            if (!we_q) rdat_q[win_q*OBW +: OBW] <= i_dn_rdat;
            be_q <= be_clr;
            if (pick_any) begin
              win_q      <= pick_idx;
              dn_we_q    <= src_we;
              dn_addr_q  <= dn_addr_d;
              dn_wdat_q  <= dn_wdat_d;
              dn_be_q    <= dn_be_d;
              dn_valid_q <= 1'b1;
              state_q    <= CMD;
            end else begin
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            resp_valid_q <= 1'b0;
            rdy_q        <= 1'b1;
            state_q      <= IDLE;
          end
        end
      endcase
    end
  end

  assign o_req_ready  = rdy_q;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_rdat  = rdat_q;
  assign o_dn_valid   = dn_valid_q;
  assign o_dn_we      = dn_we_q;
  assign o_dn_addr    = dn_addr_q;
  assign o_dn_wdat    = dn_wdat_q;
  assign o_dn_be      = dn_be_q;

endmodule

// File: tb/tb_dw_split_seq.sv
// Randomized bench for dw_split_seq against a window-list reference model.
module tb_dw_split_seq;

  localparam int unsigned AW = 32;
  localparam int unsigned IB = 8;
  localparam int unsigned OB = 4;
  localparam int unsigned N  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_req_valid = 1'b0, i_req_we = 1'b0;
  logic [AW-1:0]   i_req_addr = '0;
  logic [IB*8-1:0] i_req_wdat = '0;
  logic [IB-1:0]   i_req_be = '0;
  logic            i_resp_ready = 1'b0, i_dn_ready = 1'b0, i_dn_rvalid = 1'b0;
  logic [OB*8-1:0] i_dn_rdat = '0;
  logic            o_req_ready, o_resp_valid, o_dn_valid, o_dn_we;
  logic [IB*8-1:0] o_resp_rdat;
  logic [AW-1:0]   o_dn_addr;
  logic [OB*8-1:0] o_dn_wdat;
  logic [OB-1:0]   o_dn_be;

  always #5 clk = ~clk;

  dw_split_seq #(.IN_P_DW_BYTES(3), .OUT_P_DW_BYTES(2), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdat(i_req_wdat), .i_req_be(i_req_be),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready), .o_resp_rdat(o_resp_rdat),
    .o_dn_valid(o_dn_valid), .i_dn_ready(i_dn_ready), .o_dn_we(o_dn_we),
    .o_dn_addr(o_dn_addr), .o_dn_wdat(o_dn_wdat), .o_dn_be(o_dn_be),
    .i_dn_rvalid(i_dn_rvalid), .i_dn_rdat(i_dn_rdat)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] last_rdat = '0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  be;
    logic [31:0] rdat;
  } beat_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dn_valid"}, o_dn_valid, 0);
    check({tag, "_resp_valid"}, o_resp_valid, 0);
  endtask

  task automatic wait_ready();
    int cyc = 0;
    while (!o_req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("req_ready_wait", o_req_ready, 1);
  endtask

  // Drives one request; the model lists the expected beats and the wide response.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [63:0] wdat,
                     input logic [7:0] be, input int dn_stall, input int resp_stall,
                     input bit spurious, input bit use_fix, input logic [31:0] rd_fix);
    beat_t q[$];
    beat_t b;
    logic [63:0] exp_rdat = '0;
    for (int w = 0; w < N; w++) begin
      logic [3:0] bs;
      bs = 4'((be >> (w * OB)) & 8'hF);
      if (bs != 4'h0) begin
        b.addr = (addr & ~32'(IB - 1)) + 32'(w * OB);
        b.wdat = 32'(wdat >> (w * 32));
        b.be   = bs;
        b.rdat = use_fix ? rd_fix : $urandom;
        if (!we) exp_rdat |= 64'(b.rdat) << (w * 32);
        q.push_back(b);
      end
    end

    wait_ready();
    if (spurious) begin
      i_dn_rvalid = 1'b1;
      i_dn_rdat   = $urandom;
      @(negedge clk);
      i_dn_rvalid = 1'b0;
      check("idle_spurious_rdat", o_resp_rdat, last_rdat);
      check_idle_outputs("idle_spurious");
    end
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_wdat  = wdat;
    i_req_be    = be;
    @(negedge clk);
    i_req_valid = 1'b0;
    check("req_ready_low", o_req_ready, 0);

    foreach (q[k]) begin
      check("dn_valid", o_dn_valid, 1);
      check("dn_we", o_dn_we, we);
      check("dn_addr", o_dn_addr, q[k].addr);
      check("dn_wdat", o_dn_wdat, q[k].wdat);
      check("dn_be", o_dn_be, q[k].be);
      check("resp_early", o_resp_valid, 0);
      for (int s = 0; s < dn_stall; s++) begin
        if (spurious) begin
          i_dn_rvalid = 1'b1;
          i_dn_rdat   = $urandom;
        end
        @(negedge clk);
        i_dn_rvalid = 1'b0;
        check("stall_dn_valid", o_dn_valid, 1);
        check("stall_dn_addr", o_dn_addr, q[k].addr);
        check("stall_dn_wdat", o_dn_wdat, q[k].wdat);
        check("stall_dn_be", o_dn_be, q[k].be);
      end
      i_dn_ready = 1'b1;
      @(negedge clk);
      i_dn_ready = 1'b0;
      check("dn_valid_drop", o_dn_valid, 0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("wait_dn_valid", o_dn_valid, 0);
      end
      i_dn_rvalid = 1'b1;
      i_dn_rdat   = q[k].rdat;
      @(negedge clk);
      i_dn_rvalid = 1'b0;
    end

    for (int s = 0; s <= resp_stall; s++) begin
      check("resp_valid", o_resp_valid, 1);
      check("resp_rdat", o_resp_rdat, exp_rdat);
      check("resp_req_ready", o_req_ready, 0);
      check("resp_dn_valid", o_dn_valid, 0);
      if (s < resp_stall) @(negedge clk);
    end
    i_resp_ready = 1'b1;
    @(negedge clk);
    i_resp_ready = 1'b0;
    check("resp_drop", o_resp_valid, 0);
    check("req_ready_back", o_req_ready, 1);
    last_rdat = exp_rdat;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready", o_req_ready, 0);
    check("rst_resp_rdat", o_resp_rdat, 64'h0);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", o_req_ready, 1);

    txn(1'b1, 32'h1000, 64'h1122334455667788, 8'hFF, 0, 0, 1'b0, 1'b0, 32'h0);
    txn(1'b0, 32'h2000, 64'h0, 8'hF0, 0, 0, 1'b0, 1'b1, 32'hDEADBEEF);
    check("deadbeef_rdat", last_rdat, 64'hDEADBEEF00000000);
    txn(1'b0, 32'h3004, $urandom, 8'h00, 0, 0, 1'b1, 1'b0, 32'h0);
    txn(1'b1, 32'h4000, 64'hA5A5A5A5CAFEF00D, 8'h0C, 3, 4, 1'b1, 1'b0, 32'h0);
    txn(1'b0, 32'h5008, 64'h0, 8'hF0, 0, 4, 1'b1, 1'b0, 32'h0);
    txn(1'b0, 32'h6000, {$urandom, $urandom}, 8'h81, 1, 0, 1'b1, 1'b0, 32'h0);

    for (int t = 0; t < 40; t++) begin
      logic [7:0] be;
      be = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      txn(1'($urandom), $urandom, {$urandom, $urandom}, be,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          1'($urandom), 1'b0, 32'h0);
    end

    // Reset while the first beat of a read is outstanding.
    wait_ready();
    i_req_valid = 1'b1;
    i_req_we    = 1'b0;
    i_req_addr  = 32'h7000;
    i_req_be    = 8'hFF;
    @(negedge clk);
    i_req_valid = 1'b0;
    i_dn_ready  = 1'b1;
    @(negedge clk);
    i_dn_ready  = 1'b0;
    check("pre_rst_wait", o_dn_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", o_req_ready, 0);
    check("mid_rst_dn_addr", o_dn_addr, 32'h0);
    check("mid_rst_dn_be", o_dn_be, 4'h0);
    check("mid_rst_rdat", o_resp_rdat, 64'h0);
    check_idle_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_ready", o_req_ready, 1);
    check_idle_outputs("after_rst");
    last_rdat = '0;
    txn(1'b0, 32'h8000, 64'h0, 8'hFF, 1, 1, 1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
